fir_mac_sequencer: RTL

Controller that sequences the shared 16×16 ALU multiplier across the taps of a direct-form FIR filter. It accepts one input sample per handshake and stores it in a circular sample history. It then issues one (sample, coefficient) pair to the ALU per cycle, accumulates the registered products into a 39-bit accumulator, and presents the finished output through a valid/ready handshake. It sits between the sample source and the ALU, and owns the coefficient store and the history buffer.

---
 rtl/fir_pkg.sv | 27 ++
 rtl/fir_mac_sequencer_if.sv | 22 ++
 rtl/fir_sample_ring.sv | 41 ++++
 rtl/fir_mac_sequencer.sv | 105 ++++++++++
 4 files changed

// File: rtl/fir_pkg.sv
// rtl/fir_pkg.sv - shared widths, state encoding and saturation helper for the FIR MAC sequencer
package fir_pkg;

    localparam int DW      = 16;
    localparam int ACC_W   = 39;
    localparam int ALU_LAT = 1;

    typedef enum logic [1:0] {
        IDLE,
        MAC,
        DRAIN,
        OUT
    } state_t;

    localparam logic signed [ACC_W-1:0] SAT_MAX = 39'sd32767;
    localparam logic signed [ACC_W-1:0] SAT_MIN = -39'sd32768;

    function automatic logic signed [DW-1:0] sat16(input logic signed [ACC_W-1:0] v);
        if (v > SAT_MAX) begin
            return DW'(SAT_MAX);
        end else if (v < SAT_MIN) begin
            return DW'(SAT_MIN);
        end
        return v[DW-1:0];
    endfunction

endpackage

// File: rtl/fir_mac_sequencer_if.sv
// rtl/fir_mac_sequencer_if.sv - sample input and result output handshakes of the FIR MAC sequencer
interface fir_mac_sequencer_if;

    logic                             in_valid;
    logic                             in_ready;
    logic signed [fir_pkg::DW-1:0]    in_sample;
    logic                             out_valid;
    logic                             out_ready;
    logic signed [fir_pkg::ACC_W-1:0] out_data;
    logic signed [fir_pkg::DW-1:0]    out_q;

    modport master (
        output in_valid, in_sample, out_ready,
        input  in_ready, out_valid, out_data, out_q
    );

    modport slave (
        input  in_valid, in_sample, out_ready,
        output in_ready, out_valid, out_data, out_q
    );

endinterface

// File: rtl/fir_sample_ring.sv
// rtl/fir_sample_ring.sv - circular sample history with write pointer and tap-relative read
module fir_sample_ring
    import fir_pkg::*;
#(
    parameter  int TAPS = 16,
    localparam int AW   = $clog2(TAPS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 we,
    input  logic signed [DW-1:0] wdata,
    input  logic                 advance,
    input  logic [AW-1:0]        k,
    output logic signed [DW-1:0] rd_data
);

    logic signed [DW-1:0] hist [TAPS];
    logic [AW-1:0]        wptr;
    logic [AW-1:0]        raddr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr <= '0;
            for (int i = 0; i < TAPS; i++) begin
                hist[i] <= '0;
            end
        end else begin
            if (we) begin
                hist[wptr] <= wdata;
            end
            if (advance) begin
                wptr <= wptr + AW'(1);
            end
        end
    end

    // TAPS is a power of two, so the AW-bit subtraction is the modular tap address
    assign raddr   = wptr - k;
    assign rd_data = hist[raddr];

endmodule

// File: rtl/fir_mac_sequencer.sv
// rtl/fir_mac_sequencer.sv - sequences one shared multiplier across FIR taps; FIR_SAT_EN selects saturating out_q
module fir_mac_sequencer
    import fir_pkg::*;
#(
    parameter  int TAPS  = 16,
    parameter  int SHIFT = 15,
    localparam int AW    = $clog2(TAPS)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    fir_mac_sequencer_if.slave      s,
    input  logic                    coef_we,
    input  logic [AW-1:0]           coef_waddr,
    input  logic signed [DW-1:0]    coef_wdata,
    output logic                    busy,
    output logic signed [DW-1:0]    alu_x,
    output logic signed [DW-1:0]    alu_b,
    input  logic signed [ACC_W-1:0] alu_y
);

    state_t                  state, state_nxt;
    logic [AW-1:0]           k;
    logic signed [ACC_W-1:0] acc;
    logic signed [DW-1:0]    coef [TAPS];
    logic signed [DW-1:0]    hist_rd;
    logic                    accept;

    assign accept = (state == IDLE) && s.in_valid;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (s.in_valid)            state_nxt = MAC;
            MAC:     if (k == AW'(TAPS - 1))    state_nxt = DRAIN;
            DRAIN:                              state_nxt = OUT;
            OUT:     if (s.out_ready)           state_nxt = IDLE;
            default:                            state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            k   <= '0;
            acc <= '0;
            for (int i = 0; i < TAPS; i++) begin
                coef[i] <= '0;
            end
        end else begin
            if (state == IDLE && coef_we) begin
                coef[coef_waddr] <= coef_wdata;
            end
            case (state)
                IDLE: begin
                    if (accept) begin
                        acc <= '0;
                        k   <= '0;
                    end
                end
                MAC: begin
                    k <= k + AW'(1);
                    // products lag their operands, so the first MAC cycle has nothing to add yet
                    if (int'(k) >= ALU_LAT) begin
                        acc <= acc + alu_y;
                    end
                end
                DRAIN:   acc <= acc + alu_y;
                default: ;
            endcase
        end
    end

    fir_sample_ring #(.TAPS(TAPS)) u_ring (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (accept),
        .wdata   (s.in_sample),
        .advance (state == DRAIN),
        .k       (k),
        .rd_data (hist_rd)
    );

    assign s.in_ready  = (state == IDLE);
    assign busy        = (state != IDLE);
    assign s.out_valid = (state == OUT);
    assign s.out_data  = acc;
    assign alu_x       = (state == MAC) ? hist_rd : '0;
    assign alu_b       = (state == MAC) ? coef[k] : '0;

`ifdef FIR_SAT_EN
    logic signed [ACC_W-1:0] acc_shifted;
    assign acc_shifted = acc >>> SHIFT;
    assign s.out_q     = sat16(acc_shifted);
`else
    assign s.out_q     = acc[SHIFT+DW-1:SHIFT];
`endif

endmodule
